// File: rtl/mealy_run_end_detector.sv
// rtl/mealy_run_end_detector.sv - Mealy detector for a run of >= min_run mark bits ended by a space bit
// Run-length counter and detection counter both saturate rather than wrap.
module mealy_run_end_detector #(
  parameter int   RUN_WIDTH   = 4,
  parameter int   COUNT_WIDTH = 8,
  parameter logic MARK_POL    = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   x_in,
  input  logic [RUN_WIDTH-1:0]   min_run,
  input  logic                   invert,
  input  logic                   clr_count,
  output logic                   y_out,
  output logic                   y_reg,
  output logic [RUN_WIDTH-1:0]   run_len,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] det_count,
  output logic                   count_sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  localparam logic [RUN_WIDTH-1:0]   RUN_ONE   = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RUN_WIDTH-1:0]   RUN_MAX   = {RUN_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [RUN_WIDTH-1:0]   r_run_len;
  logic [RUN_WIDTH-1:0]   w_run_nxt;
  logic [RUN_WIDTH-1:0]   w_run_inc;
  logic [RUN_WIDTH-1:0]   w_eff_min;
  logic [COUNT_WIDTH-1:0] r_det_count;
  logic                   r_y_reg;
  logic                   w_mark_level;
  logic                   w_mark;
  logic                   w_space;
  logic                   w_detect;

  assign w_mark_level = (x_in == (MARK_POL ^ invert));
  assign w_mark       = enable & w_mark_level;
  assign w_space      = enable & ~w_mark_level;
  assign w_eff_min    = (min_run == '0) ? RUN_ONE : min_run;
  assign w_run_inc    = (r_run_len == RUN_MAX) ? r_run_len : (r_run_len + RUN_ONE);
  assign w_detect     = (r_state == S_ARMED) & w_space;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_len;
    case (r_state)
      S_IDLE: begin
        if (w_mark) begin
          w_run_nxt   = RUN_ONE;
          w_state_nxt = (w_eff_min == RUN_ONE) ? S_ARMED : S_RUN;
        end else if (w_space) begin
          w_run_nxt = '0;
        end
      end
      S_RUN: begin
        // min_run is re-evaluated on every mark, so mid-run changes apply here
        if (w_mark) begin
          w_run_nxt   = w_run_inc;
          w_state_nxt = (w_run_inc >= w_eff_min) ? S_ARMED : S_RUN;
        end else if (w_space) begin
          w_run_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_ARMED: begin
        if (w_mark) begin
          w_run_nxt = w_run_inc;
        end else if (w_space) begin
          w_run_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_run_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_run_len   <= '0;
      r_y_reg     <= 1'b0;
      r_det_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_len <= w_run_nxt;
      r_y_reg   <= w_detect;
      // a clear in the same cycle as a detection takes priority
      if (clr_count) begin
        r_det_count <= '0;
      end else if (w_detect && (r_det_count != COUNT_MAX)) begin
        r_det_count <= r_det_count + COUNT_ONE;
      end
    end
  end

  assign y_out     = w_detect;
  assign y_reg     = r_y_reg;
  assign run_len   = r_run_len;
  assign armed     = (r_state == S_ARMED);
  assign det_count = r_det_count;
  assign count_sat = (r_det_count == COUNT_MAX);

endmodule

// File: tb/tb_mealy_run_end_detector.sv
// tb/tb_mealy_run_end_detector.sv - directed self-checking bench for mealy_run_end_detector
// A second instance with a 2-bit detection counter covers counter saturation.
module tb_mealy_run_end_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       x_in = 1'b0;
  logic [3:0] min_run = 4'd1;
  logic       invert = 1'b0;
  logic       clr_count = 1'b0;

  logic       y_out, y_reg, armed, count_sat;
  logic [3:0] run_len;
  logic [7:0] det_count;

  logic       d2_y_out, d2_y_reg, d2_armed, d2_count_sat;
  logic [3:0] d2_run_len;
  logic [1:0] d2_det_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mealy_run_end_detector #(.RUN_WIDTH(4), .COUNT_WIDTH(8), .MARK_POL(1'b1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .x_in(x_in),
    .min_run(min_run), .invert(invert), .clr_count(clr_count),
    .y_out(y_out), .y_reg(y_reg), .run_len(run_len), .armed(armed),
    .det_count(det_count), .count_sat(count_sat)
  );

  mealy_run_end_detector #(.RUN_WIDTH(4), .COUNT_WIDTH(2), .MARK_POL(1'b1)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .x_in(x_in),
    .min_run(min_run), .invert(invert), .clr_count(clr_count),
    .y_out(d2_y_out), .y_reg(d2_y_reg), .run_len(d2_run_len), .armed(d2_armed),
    .det_count(d2_det_count), .count_sat(d2_count_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample mid-cycle, check the Mealy output before the edge,
  // then check the registered view just after the edge.
  task automatic step(input string tag, input logic x, input logic en,
                      input logic exp_y, input logic [3:0] exp_run);
    x_in   = x;
    enable = en;
    #2;
    chk({tag, " y_out"}, y_out, exp_y);
    @(posedge clock);
    #1;
    chk({tag, " y_reg"}, y_reg, exp_y);
    chk({tag, " run_len"}, run_len, exp_run);
  endtask

  task automatic clear_counts();
    clr_count = 1'b1;
    enable    = 1'b0;
    @(posedge clock);
    #1;
    clr_count = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst y_out", y_out, 1'b0);
    chk("rst y_reg", y_reg, 1'b0);
    chk("rst run_len", run_len, 4'd0);
    chk("rst armed", armed, 1'b0);
    chk("rst det_count", det_count, 8'd0);
    chk("rst count_sat", count_sat, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // min_run=1: 0,1,0,1,1,0
    min_run = 4'd1;
    step("s1c1", 1'b0, 1'b1, 1'b0, 4'd0);
    step("s1c2", 1'b1, 1'b1, 1'b0, 4'd1);
    chk("s1c2 armed", armed, 1'b1);
    step("s1c3", 1'b0, 1'b1, 1'b1, 4'd0);
    step("s1c4", 1'b1, 1'b1, 1'b0, 4'd1);
    step("s1c5", 1'b1, 1'b1, 1'b0, 4'd2);
    step("s1c6", 1'b0, 1'b1, 1'b1, 4'd0);
    chk("s1 det_count", det_count, 8'd2);
    step("s1 idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // min_run=3: 1,1,0,1,1,1,0
    clear_counts();
    chk("clr det_count", det_count, 8'd0);
    min_run = 4'd3;
    step("s2c1", 1'b1, 1'b1, 1'b0, 4'd1);
    step("s2c2", 1'b1, 1'b1, 1'b0, 4'd2);
    step("s2c3", 1'b0, 1'b1, 1'b0, 4'd0);
    step("s2c4", 1'b1, 1'b1, 1'b0, 4'd1);
    step("s2c5", 1'b1, 1'b1, 1'b0, 4'd2);
    chk("s2c5 armed", armed, 1'b0);
    step("s2c6", 1'b1, 1'b1, 1'b0, 4'd3);
    chk("s2c6 armed", armed, 1'b1);
    step("s2c7", 1'b0, 1'b1, 1'b1, 4'd0);
    chk("s2 det_count", det_count, 8'd1);

    // enable gap with min_run=2
    clear_counts();
    min_run = 4'd2;
    step("s3c1", 1'b1, 1'b1, 1'b0, 4'd1);
    step("s3g1", 1'b0, 1'b0, 1'b0, 4'd1);
    step("s3g2", 1'b0, 1'b0, 1'b0, 4'd1);
    step("s3g3", 1'b0, 1'b0, 1'b0, 4'd1);
    chk("s3 gap armed", armed, 1'b0);
    step("s3c2", 1'b1, 1'b1, 1'b0, 4'd2);
    step("s3c3", 1'b0, 1'b1, 1'b1, 4'd0);
    chk("s3 det_count", det_count, 8'd1);

    // invert: marks are zeros
    clear_counts();
    invert = 1'b1;
    step("s4c1", 1'b0, 1'b1, 1'b0, 4'd1);
    step("s4c2", 1'b0, 1'b1, 1'b0, 4'd2);
    step("s4c3", 1'b1, 1'b1, 1'b1, 4'd0);
    step("s4c4", 1'b1, 1'b1, 1'b0, 4'd0);
    step("s4c5", 1'b0, 1'b1, 1'b0, 4'd1);
    step("s4c6", 1'b1, 1'b1, 1'b0, 4'd0);
    chk("s4 det_count", det_count, 8'd1);
    invert = 1'b0;

    // run_len saturation, then detection counter saturation
    clear_counts();
    for (int i = 1; i <= 20; i++) begin
      step("s5 mark", 1'b1, 1'b1, 1'b0, (i > 15) ? 4'd15 : 4'(i));
    end
    step("s5 end", 1'b0, 1'b1, 1'b1, 4'd0);
    min_run = 4'd1;
    for (int i = 0; i < 4; i++) begin
      step("s5 m", 1'b1, 1'b1, 1'b0, 4'd1);
      step("s5 s", 1'b0, 1'b1, 1'b1, 4'd0);
    end
    chk("s5 det_count", det_count, 8'd5);
    chk("s5 count_sat", count_sat, 1'b0);
    chk("s5 d2 det_count", d2_det_count, 2'd3);
    chk("s5 d2 count_sat", d2_count_sat, 1'b1);
    step("s5 m6", 1'b1, 1'b1, 1'b0, 4'd1);
    clr_count = 1'b1;
    step("s5 s6", 1'b0, 1'b1, 1'b1, 4'd0);
    clr_count = 1'b0;
    chk("s5 clr det_count", det_count, 8'd0);
    chk("s5 clr d2 det_count", d2_det_count, 2'd0);
    chk("s5 clr d2 count_sat", d2_count_sat, 1'b0);

    // asynchronous reset while ARMED with run_len=5
    step("s6 m", 1'b1, 1'b1, 1'b0, 4'd1);
    step("s6 s", 1'b0, 1'b1, 1'b1, 4'd0);
    min_run = 4'd2;
    for (int i = 1; i <= 5; i++) begin
      step("s6 run", 1'b1, 1'b1, 1'b0, 4'(i));
    end
    chk("s6 pre armed", armed, 1'b1);
    chk("s6 pre det_count", det_count, 8'd1);
    x_in  = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("s6 rst run_len", run_len, 4'd0);
    chk("s6 rst armed", armed, 1'b0);
    chk("s6 rst y_out", y_out, 1'b0);
    chk("s6 rst det_count", det_count, 8'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("s6 after", 1'b0, 1'b1, 1'b0, 4'd0);
    chk("s6 after det_count", det_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
